// File: rtl/atm_cash_dispenser_pkg.sv
// Shared ATM definitions: menu codes, note denominations and the cash
// dispenser state encoding.
package atm_cash_dispenser_pkg;

  localparam int AMT_W     = 11;
  localparam int NUM_NOTES = 4;

  typedef enum logic [2:0] {
    MENU_BALANCE  = 3'd0,
    MENU_WITHDRAW = 3'd1,
    MENU_DEPOSIT  = 3'd2,
    MENU_PIN      = 3'd3,
    MENU_EXIT     = 3'd4
  } menu_e;

  typedef enum logic [1:0] {
    NOTE_100 = 2'd0,
    NOTE_50  = 2'd1,
    NOTE_20  = 2'd2,
    NOTE_10  = 2'd3
  } note_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PLAN     = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_FINISH   = 2'd3
  } disp_state_e;

  function automatic logic [AMT_W-1:0] note_value(input note_e n);
    case (n)
      NOTE_100: note_value = 11'd100;
      NOTE_50:  note_value = 11'd50;
      NOTE_20:  note_value = 11'd20;
      default:  note_value = 11'd10;
    endcase
  endfunction

endpackage

// File: rtl/atm_note_planner.sv
// One greedy planning step: how many notes of one denomination to pay,
// bounded by what the cassette holds, and what is left to pay afterwards.
module atm_note_planner
  import atm_cash_dispenser_pkg::*;
#(
  parameter int NOTE_W = 8
) (
  input  logic [AMT_W-1:0]  remaining,
  input  note_e             denom,
  input  logic [NOTE_W-1:0] stock,
  output logic [NOTE_W-1:0] plan,
  output logic [AMT_W-1:0]  remaining_next
);

  localparam int CW = (NOTE_W > AMT_W) ? NOTE_W : AMT_W;

  logic [AMT_W-1:0] quotient;
  logic [CW-1:0]    quotient_w;
  logic [CW-1:0]    stock_w;
  logic [CW-1:0]    paid;

  // Division by a constant per denomination keeps this to fixed divider logic.
  always_comb begin
    quotient = '0;
    case (denom)
      NOTE_100: quotient = remaining / 11'd100;
      NOTE_50:  quotient = remaining / 11'd50;
      NOTE_20:  quotient = remaining / 11'd20;
      default:  quotient = remaining / 11'd10;
    endcase
  end

  always_comb begin
    quotient_w     = CW'(quotient);
    stock_w        = CW'(stock);
    plan           = (quotient_w < stock_w) ? NOTE_W'(quotient_w) : stock;
    paid           = CW'(plan) * CW'(note_value(denom));
    remaining_next = remaining - AMT_W'(paid);
  end

endmodule

// File: rtl/atm_cash_dispenser.sv
// Cash dispenser: greedily plans a withdrawal over four cassettes, then
// hands notes one at a time to the mechanism with a valid/ready handshake.
module atm_cash_dispenser
  import atm_cash_dispenser_pkg::*;
#(
  parameter int INIT_NOTES = 20,
  parameter int NOTE_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dispense_req,
  input  logic [AMT_W-1:0] amount,
  output logic             note_valid,
  output logic [1:0]       note_type,
  input  logic             note_ready,
  output logic             busy,
  output logic             done,
  output logic             reject,
  output logic [3:0]       cassette_empty
);

  disp_state_e       state, state_next;
  logic [AMT_W-1:0]  remaining;
  logic [1:0]        plan_idx;
  logic              amount_zero;
  logic              reject_q;
  logic [NOTE_W-1:0] plan_cnt [NUM_NOTES];
  logic [NOTE_W-1:0] cassette [NUM_NOTES];

  logic [NOTE_W-1:0] plan_d;
  logic [AMT_W-1:0]  remaining_next;
  logic              plan_ok;
  note_e             cur_type;
  logic              last_note;
  logic              handshake;

  atm_note_planner #(.NOTE_W(NOTE_W)) u_planner (
    .remaining      (remaining),
    .denom          (note_e'(plan_idx)),
    .stock          (cassette[plan_idx]),
    .plan           (plan_d),
    .remaining_next (remaining_next)
  );

  assign plan_ok   = (remaining_next == '0) && !amount_zero;
  assign handshake = (state == ST_DISPENSE) && note_ready;

  // Largest denomination with notes still owed is the one on offer.
  always_comb begin
    cur_type = NOTE_100;
    for (int i = NUM_NOTES - 1; i >= 0; i--)
      if (plan_cnt[i] != '0) cur_type = note_e'(i);
  end

  always_comb begin
    last_note = (plan_cnt[cur_type] == NOTE_W'(1));
    for (int i = 0; i < NUM_NOTES; i++)
      if (note_e'(i) != cur_type && plan_cnt[i] != '0) last_note = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    note_valid = 1'b0;
    note_type  = 2'd0;
    busy       = (state != ST_IDLE);
    done       = 1'b0;
    reject     = reject_q;
    case (state)
      ST_IDLE:     if (dispense_req) state_next = ST_PLAN;
      ST_PLAN:     if (plan_idx == 2'd3) state_next = plan_ok ? ST_DISPENSE : ST_IDLE;
      ST_DISPENSE: begin
        note_valid = 1'b1;
        note_type  = cur_type;
        if (handshake && last_note) state_next = ST_FINISH;
      end
      ST_FINISH: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default:     state_next = ST_IDLE;
    endcase
  end

  // Reset refills the cassettes, abandoning any payout in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining   <= '0;
      plan_idx    <= 2'd0;
      amount_zero <= 1'b0;
      reject_q    <= 1'b0;
      for (int i = 0; i < NUM_NOTES; i++) begin
        plan_cnt[i] <= '0;
        cassette[i] <= NOTE_W'(INIT_NOTES);
      end
    end else begin
      reject_q <= 1'b0;
      case (state)
        ST_IDLE: if (dispense_req) begin
          remaining   <= amount;
          amount_zero <= (amount == '0);
          plan_idx    <= 2'd0;
        end
        ST_PLAN: begin
          plan_cnt[plan_idx] <= plan_d;
          remaining          <= remaining_next;
          plan_idx           <= plan_idx + 2'd1;
          if (plan_idx == 2'd3 && !plan_ok) begin
            reject_q <= 1'b1;
            for (int i = 0; i < NUM_NOTES; i++) plan_cnt[i] <= '0;
          end
        end
        ST_DISPENSE: if (handshake) begin
          plan_cnt[cur_type] <= plan_cnt[cur_type] - NOTE_W'(1);
          cassette[cur_type] <= cassette[cur_type] - NOTE_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cassette_empty = '0;
    for (int i = 0; i < NUM_NOTES; i++)
      cassette_empty[i] = (cassette[i] == '0);
  end

endmodule

// File: tb/tb_atm_cash_dispenser.sv
// Randomised bench for atm_cash_dispenser against a greedy payout model,
// with two instances: default cassettes and a nearly empty (2-note) one.
module tb_atm_cash_dispenser;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       dispense_req;
  logic [1:0][10:0] amount;
  logic [1:0]       note_ready;
  logic [1:0]       note_valid;
  logic [1:0][1:0]  note_type;
  logic [1:0]       busy;
  logic [1:0]       done;
  logic [1:0]       reject;
  logic [1:0][3:0]  cassette_empty;

  int total = 0;
  int bad   = 0;

  int init_notes [2] = '{20, 2};
  int denom_val  [4] = '{100, 50, 20, 10};
  int cas [2][4];
  int expq [$];
  bit exp_rej;

  always #5 clk = ~clk;

  atm_cash_dispenser dut0 (
    .clk(clk), .reset(reset), .dispense_req(dispense_req[0]), .amount(amount[0]),
    .note_valid(note_valid[0]), .note_type(note_type[0]), .note_ready(note_ready[0]),
    .busy(busy[0]), .done(done[0]), .reject(reject[0]), .cassette_empty(cassette_empty[0])
  );

  atm_cash_dispenser #(.INIT_NOTES(2), .NOTE_W(8)) dut1 (
    .clk(clk), .reset(reset), .dispense_req(dispense_req[1]), .amount(amount[1]),
    .note_valid(note_valid[1]), .note_type(note_type[1]), .note_ready(note_ready[1]),
    .busy(busy[1]), .done(done[1]), .reject(reject[1]), .cassette_empty(cassette_empty[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] expEmpty(input int u);
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (cas[u][i] == 0);
    return e;
  endfunction

  task automatic modelReset();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 4; i++) cas[u][i] = init_notes[u];
  endtask

  // Greedy payout: largest note first, never more than the cassette holds.
  task automatic modelPlan(input int u, input int amt);
    int rem, n;
    expq.delete();
    rem = amt;
    for (int i = 0; i < 4; i++) begin
      n = rem / denom_val[i];
      if (n > cas[u][i]) n = cas[u][i];
      rem -= n * denom_val[i];
      for (int k = 0; k < n; k++) expq.push_back(i);
    end
    exp_rej = (rem != 0) || (amt == 0);
  endtask

  task automatic applyStimulus(input int u, input int amt, input int ready_pct,
                               input int hold_low, input bit poke);
    int cyc;
    bit rdy;
    modelPlan(u, amt);
    @(negedge clk);
    dispense_req[u] = 1'b1;
    amount[u]       = 11'(amt);
    note_ready[u]   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      dispense_req[u] = poke && (k == 2);
      if (poke) amount[u] = 11'd50;
      checkOutput("plan_busy", 32'(busy[u]), 32'd1);
      checkOutput("plan_valid", 32'(note_valid[u]), 32'd0);
      checkOutput("plan_reject", 32'(reject[u]), 32'd0);
    end
    @(negedge clk);
    if (exp_rej) begin
      checkOutput("reject_pulse", 32'(reject[u]), 32'd1);
      checkOutput("reject_valid", 32'(note_valid[u]), 32'd0);
      checkOutput("reject_busy", 32'(busy[u]), 32'd0);
      @(negedge clk);
      checkOutput("reject_drop", 32'(reject[u]), 32'd0);
      checkOutput("reject_valid2", 32'(note_valid[u]), 32'd0);
    end else begin
      cyc = 0;
      while (expq.size() > 0 && cyc < 400) begin
        checkOutput("note_valid", 32'(note_valid[u]), 32'd1);
        checkOutput("note_type", 32'(note_type[u]), 32'(expq[0]));
        checkOutput("disp_done", 32'(done[u]), 32'd0);
        rdy = (cyc >= hold_low) && ($urandom_range(1, 100) <= ready_pct);
        note_ready[u] = rdy;
        if (rdy) begin
          cas[u][expq[0]]--;
          void'(expq.pop_front());
        end
        cyc++;
        @(negedge clk);
      end
      if (expq.size() > 0) checkOutput("dispense_timeout", 32'd0, 32'd1);
      note_ready[u] = 1'b0;
      checkOutput("done_pulse", 32'(done[u]), 32'd1);
      checkOutput("finish_valid", 32'(note_valid[u]), 32'd0);
      @(negedge clk);
      checkOutput("done_drop", 32'(done[u]), 32'd0);
      checkOutput("idle_busy", 32'(busy[u]), 32'd0);
    end
    checkOutput("cassette_empty", 32'(cassette_empty[u]), 32'(expEmpty(u)));
  endtask

  // Reset partway through a 300 payout (three 100s) after two are taken.
  task automatic resetMidDispense();
    @(negedge clk);
    dispense_req[0] = 1'b1;
    amount[0]       = 11'd300;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      dispense_req[0] = 1'b0;
    end
    checkOutput("rst_first_valid", 32'(note_valid[0]), 32'd1);
    note_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_third_valid", 32'(note_valid[0]), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst_valid", 32'(note_valid[0]), 32'd0);
    checkOutput("rst_busy", 32'(busy[0]), 32'd0);
    checkOutput("rst_done", 32'(done[0]), 32'd0);
    note_ready[0] = 1'b0;
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rst_no_done", 32'(done[0]), 32'd0);
    end
    checkOutput("rst_empty", 32'(cassette_empty[0]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int u, amt;
    reset        = 1'b1;
    dispense_req = '0;
    amount       = '0;
    note_ready   = '0;
    modelReset();
    #12;
    checkOutput("reset_valid", 32'(note_valid[0]), 32'd0);
    checkOutput("reset_type", 32'(note_type[0]), 32'd0);
    checkOutput("reset_busy", 32'(busy[0]), 32'd0);
    checkOutput("reset_done", 32'(done[0]), 32'd0);
    checkOutput("reset_reject", 32'(reject[0]), 32'd0);
    checkOutput("reset_empty", 32'(cassette_empty[0]), 32'd0);
    checkOutput("reset_empty1", 32'(cassette_empty[1]), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(0, 380, 100, 0, 1'b0);
    applyStimulus(0, 105, 100, 0, 1'b0);
    applyStimulus(0, 0, 100, 0, 1'b0);
    applyStimulus(1, 400, 100, 0, 1'b0);
    applyStimulus(1, 300, 100, 0, 1'b0);
    applyStimulus(0, 100, 100, 3, 1'b1);
    resetMidDispense();
    applyStimulus(0, 2000, 100, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      u   = int'($urandom_range(0, 1));
      amt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047))
                                        : 10 * int'($urandom_range(0, 60));
      applyStimulus(u, amt, int'($urandom_range(30, 100)), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atm_cash_dispenser.md
ATM_CASH_DISPENSER -- requirements
Module: atm_cash_dispenser

Interface
REQ-001 Parameter INIT_NOTES, default 20, notes loaded into each cassette at reset.
REQ-002 Parameter NOTE_W, default 8, width of each cassette note counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 dispense_req  input  1  one-cycle request from ATM after an error-free withdrawal.
REQ-006 amount  input  11  withdrawal amount in currency units, sampled with dispense_req.
REQ-007 note_valid  output  1  a note is offered to the mechanism.
REQ-008 note_type  output  2  denomination offered: 0=100, 1=50, 2=20, 3=10.
REQ-009 note_ready  input  1  mechanism accepts the offered note this cycle.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse after the last note is accepted.
REQ-012 reject  output  1  one-cycle pulse when a request cannot be paid; no notes are offered.
REQ-013 cassette_empty  output  4  bit i high when the cassette for note_type i holds 0 notes.

Function
REQ-014 The FSM SHALL have states IDLE, PLAN, DISPENSE, FINISH.
REQ-015 IDLE: dispense_req=1 latches amount into an 11-bit remaining register and moves to PLAN; dispense_req outside IDLE is ignored.
REQ-016 PLAN SHALL take exactly 4 cycles, one per denomination in order 100, 50, 20, 10: plan_d = min(remaining / d, cassette_d), remaining -= plan_d * d.
REQ-017 After the 4th PLAN cycle, remaining != 0 or amount == 0 SHALL pulse reject for one cycle and return to IDLE with cassettes unchanged.
REQ-018 Otherwise DISPENSE is entered; notes are offered largest denomination first, all notes of one type before the next.
REQ-019 note_valid and note_type SHALL stay stable until the cycle note_valid & note_ready is high; note_valid never drops without a handshake.
REQ-020 Each handshake SHALL decrement that cassette counter and that plan counter by 1; the next note may be offered on the following cycle.
REQ-021 When all plan counters reach 0, FINISH SHALL pulse done for one cycle, then IDLE.
REQ-022 Greedy planning is final: an amount payable only by a non-greedy combination SHALL be rejected.
REQ-023 Cassette counters SHALL never wrap below 0; plan ensures plan_d <= cassette_d.
REQ-024 Latency: dispense_req in cycle N -> first note_valid in cycle N+5, or reject in cycle N+5.

Reset
REQ-025 reset SHALL force IDLE, note_valid=0, note_type=0, busy=0, done=0, reject=0, all plan counters 0, remaining 0.
REQ-026 reset SHALL reload every cassette counter to INIT_NOTES (cassette_empty=0 when INIT_NOTES>0), including mid-dispense; the partial payout is abandoned.

Structure
REQ-027 Denomination codes, values (100/50/20/10) and FSM state encodings SHALL live in the shared ATM package alongside the ATM menu codes.
REQ-028 One sub-module, atm_note_planner, SHALL compute plan_d and new remaining for one denomination per cycle (constant divide, min, multiply-subtract).

Verification
REQ-029 Defaults, amount=380 -> notes 100,100,100,50,20,10 with note_ready=1, done pulse, cassettes 17/19/19/19.
REQ-030 amount=105 -> reject pulse at N+5, no note_valid, cassettes unchanged; amount=0 -> same.
REQ-031 INIT_NOTES=2, amount=400 -> reject, cassettes 2/2/2/2; then amount=300 -> 100,100,50,50, done, cassette_empty=4'b0011.
REQ-032 amount=100, note_ready low 3 cycles -> note_valid=1, note_type=0 stable all 3 cycles; accepted on 4th; second dispense_req while busy ignored.
REQ-033 reset asserted after 2 of 3 notes for amount=300 -> note_valid=0 immediately, busy=0, cassettes back to INIT_NOTES, no done.
